// File: rtl/dmem_write_buffer_pkg.sv
// dmem_write_buffer_pkg
// Shared types and geometry for the data-memory write buffer.
// The bus/memory geometry lives here rather than as module parameters so the
// queue entry struct, the forwarding matcher and the top always agree on it.
//   DATA_BIT_WIDTH : data and address bus width
//   DMEMADDRBITS   : byte-address bits decoded by the data memory
//   DMEMWORDBITS   : byte-offset bits; word index = addr[DMEMADDRBITS-1:DMEMWORDBITS]
//   WBUF_DEPTH     : queue entries (power of two, >= 2)
package dmem_write_buffer_pkg;

  localparam int DATA_BIT_WIDTH = 32;
  localparam int DMEMADDRBITS   = 13;
  localparam int DMEMWORDBITS   = 2;
  localparam int WBUF_DEPTH     = 4;

  localparam int WBUF_PTR_BITS  = $clog2(WBUF_DEPTH);
  localparam int WORD_IDX_BITS  = DMEMADDRBITS - DMEMWORDBITS;

  typedef logic [DATA_BIT_WIDTH-1:0] word_t;
  typedef logic [WORD_IDX_BITS-1:0]  word_idx_t;
  typedef logic [WBUF_PTR_BITS-1:0]  wbuf_ptr_t;
  typedef logic [WBUF_PTR_BITS:0]    wbuf_count_t;

  typedef struct packed {
    logic      valid;
    word_idx_t wordIdx;
    word_t     data;
  } wbuf_entry_t;

  localparam wbuf_count_t WBUF_FULL = wbuf_count_t'(WBUF_DEPTH);

  // Word index decoded by the memory from a byte address.
  function automatic word_idx_t addr_to_word(input word_t addr);
    return addr[DMEMADDRBITS-1:DMEMWORDBITS];
  endfunction

  // Byte address for a word index: offset and undecoded upper bits are 0.
  function automatic word_t word_to_addr(input word_idx_t idx);
    word_t addr;
    addr = '0;
    addr[DMEMADDRBITS-1:DMEMWORDBITS] = idx;
    return addr;
  endfunction

endpackage

// File: rtl/dmem_write_buffer_forward.sv
// wbuf_forward_match
// Combinational store-to-load forwarding selector. Scans the queue from the
// oldest entry (head) towards the youngest; a later match overrides an
// earlier one, so the youngest matching store wins.
//   entries  : queue storage
//   head     : index of the oldest entry
//   count    : number of occupied entries
//   cmp_word : word index of the load
//   hit      : some valid entry matches cmp_word
//   hit_data : data of the youngest matching entry (0 on a miss)
module wbuf_forward_match
  import dmem_write_buffer_pkg::*;
(
  input  wbuf_entry_t entries [WBUF_DEPTH],
  input  wbuf_ptr_t   head,
  input  wbuf_count_t count,
  input  word_idx_t   cmp_word,
  output logic        hit,
  output word_t       hit_data
);

  // NOTE: defaults are assigned before any branch so every path drives every
  // output; combinational blocks without them infer latches.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      if ((wbuf_count_t'(k) < count)
          && entries[head + wbuf_ptr_t'(k)].valid
          && (entries[head + wbuf_ptr_t'(k)].wordIdx == cmp_word)) begin
        hit      = 1'b1;
        hit_data = entries[head + wbuf_ptr_t'(k)].data;
      end
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer
// Store queue in front of the single-port data memory. Stores are queued and
// drained one per cycle; loads are forwarded from the queue on a hit or take
// the memory port on a miss (pausing the drain). Loads always return one
// cycle later, whichever source serves them.
//   clk, reset          : posedge clock, synchronous active-high reset
//   cpuWrEn, cpuRdEn    : store / load request this cycle
//   cpuAddr, cpuDataIn  : shared byte address, store data
//   stall               : store not accepted (queue full); CPU holds request
//   cpuRdData, rdValid  : load result, valid the cycle after the load
//   bufEmpty            : queue holds no entries
//   memWrEn, memAddr,
//   memDataOut          : memory write enable, word-aligned address, write data
//   memRegOut           : memory read data for the address of the last posedge
module dmem_write_buffer
  import dmem_write_buffer_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpuWrEn,
  input  logic                      cpuRdEn,
  input  logic [DATA_BIT_WIDTH-1:0] cpuAddr,
  input  logic [DATA_BIT_WIDTH-1:0] cpuDataIn,
  output logic                      stall,
  output logic [DATA_BIT_WIDTH-1:0] cpuRdData,
  output logic                      rdValid,
  output logic                      bufEmpty,
  output logic                      memWrEn,
  output logic [DATA_BIT_WIDTH-1:0] memAddr,
  output logic [DATA_BIT_WIDTH-1:0] memDataOut,
  input  logic [DATA_BIT_WIDTH-1:0] memRegOut
);

  wbuf_entry_t entries [WBUF_DEPTH];
  wbuf_ptr_t   head;
  wbuf_ptr_t   tail;
  wbuf_count_t count;

  logic        fwd_sel;
  word_t       fwd_data;

  word_idx_t   cpu_word;
  logic        full;
  logic        push;
  logic        pop;
  logic        load_miss;
  logic        hit;
  word_t       hit_data;

  // Offset bits and bits above the decoded range never reach the memory.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{cpuAddr[DATA_BIT_WIDTH-1:DMEMADDRBITS],
                              cpuAddr[DMEMWORDBITS-1:0]};

  assign cpu_word = addr_to_word(cpuAddr);

  // The load only sees entries present at the start of the cycle; a store in
  // the same cycle is written at the posedge and is not yet visible here.
  wbuf_forward_match u_match (
    .entries  (entries),
    .head     (head),
    .count    (count),
    .cmp_word (cpu_word),
    .hit      (hit),
    .hit_data (hit_data)
  );

  // Full blocks a push even if a pop happens in the same cycle.
  assign full      = (count == WBUF_FULL);
  assign push      = cpuWrEn && !full;
  assign load_miss = cpuRdEn && !hit;
  assign pop       = !load_miss && (count != '0);

  // Outputs are forced to their idle values while reset is held, so the
  // memory sees no write during the cycle it clears itself.
  assign stall    = !reset && cpuWrEn && full;
  assign bufEmpty = reset || (count == '0);

  always_comb begin
    memWrEn    = 1'b0;
    memAddr    = '0;
    memDataOut = '0;
    if (!reset) begin
      if (load_miss) begin
        memAddr = word_to_addr(cpu_word);
      end else if (pop) begin
        memWrEn    = 1'b1;
        memAddr    = word_to_addr(entries[head].wordIdx);
        memDataOut = entries[head].data;
      end
    end
  end

  // Queue storage and pointers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      // NOTE: only the valid bits are reset; an entry's payload is never read
      // while its valid bit is clear, so the storage needs no reset.
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else begin
      // Pop and push never target the same slot: a pop needs count>0, and
      // head==tail with count>0 means full, which blocks the push.
      if (pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + wbuf_ptr_t'(1);
      end
      if (push) begin
        entries[tail] <= '{valid: 1'b1, wordIdx: cpu_word, data: cpuDataIn};
        tail          <= tail + wbuf_ptr_t'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + wbuf_count_t'(1);
        2'b01:   count <= count - wbuf_count_t'(1);
        default: count <= count;
      endcase
    end
  end

  // Load return path: both forwarded and memory-served loads complete one
  // cycle after the request.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdValid  <= 1'b0;
      fwd_sel  <= 1'b0;
      fwd_data <= '0;
    end else begin
      rdValid <= cpuRdEn;
      if (cpuRdEn) begin
        fwd_sel <= hit;
        if (hit) begin
          fwd_data <= hit_data;
        end
      end
    end
  end

  assign cpuRdData = (rdValid && !reset) ? (fwd_sel ? fwd_data : memRegOut) : '0;

endmodule

// File: tb/tb_dmem_write_buffer.sv
`timescale 1ns/1ps
module tb_dmem_write_buffer;
  import dmem_write_buffer_pkg::*;

  logic  clk = 1'b0;
  logic  reset;
  logic  cpuWrEn;
  logic  cpuRdEn;
  word_t cpuAddr;
  word_t cpuDataIn;
  logic  stall;
  word_t cpuRdData;
  logic  rdValid;
  logic  bufEmpty;
  logic  memWrEn;
  word_t memAddr;
  word_t memDataOut;
  word_t memRegOut;

  always #5 clk = ~clk;

  dmem_write_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .cpuWrEn    (cpuWrEn),
    .cpuRdEn    (cpuRdEn),
    .cpuAddr    (cpuAddr),
    .cpuDataIn  (cpuDataIn),
    .stall      (stall),
    .cpuRdData  (cpuRdData),
    .rdValid    (rdValid),
    .bufEmpty   (bufEmpty),
    .memWrEn    (memWrEn),
    .memAddr    (memAddr),
    .memDataOut (memDataOut),
    .memRegOut  (memRegOut)
  );

  // Data memory model: address/data registered at posedge, write on the
  // following negedge, combinational read of the registered word.
  localparam int MEM_WORDS = 1 << WORD_IDX_BITS;
  word_t     mem [MEM_WORDS];
  word_idx_t mem_addr_q;
  word_t     mem_data_q;
  logic      mem_we_q;
  logic      pre_en;
  word_idx_t pre_idx;
  word_t     pre_data;
  logic      unused_mem_bits;
  assign unused_mem_bits = ^{memAddr[DATA_BIT_WIDTH-1:DMEMADDRBITS], memAddr[DMEMWORDBITS-1:0]};

  always @(posedge clk) begin
    if (reset) begin
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
    end else begin
      mem_addr_q <= memAddr[DMEMADDRBITS-1:DMEMWORDBITS];
      mem_data_q <= memDataOut;
      mem_we_q   <= memWrEn;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    end else if (mem_we_q) begin
      mem[mem_addr_q] <= mem_data_q;
    end else if (pre_en) begin
      mem[pre_idx] <= pre_data;
    end
  end

  assign memRegOut = mem[mem_addr_q];

  // Scoreboard state: pend holds stores accepted but not yet written to
  // memory (popped when the DUT issues the write); ld_q holds load results
  // (popped when rdValid appears); arch is the architectural memory image.
  typedef struct {
    word_idx_t w;
    word_t     d;
  } pend_t;

  pend_t pend [$];
  word_t ld_q [$];
  word_t arch [int];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic word_t arch_rd(input word_idx_t w);
    return arch.exists(int'(w)) ? arch[int'(w)] : '0;
  endfunction

  // One clock cycle with the inputs currently driven.
  task automatic step();
    logic      e_stall;
    logic      e_hit;
    logic      e_miss;
    logic      e_drain;
    logic      was_reset;
    logic      ld_issue;
    word_t     e_addr;
    word_t     e_dout;
    word_idx_t w;
    ld_issue = 1'b0;
    @(negedge clk);
    w         = addr_to_word(cpuAddr);
    was_reset = reset;
    if (reset) begin
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_bufEmpty", 32'(bufEmpty), 32'd1);
      check("rst_memWrEn", 32'(memWrEn), 32'd0);
      check("rst_memAddr", memAddr, '0);
      check("rst_memDataOut", memDataOut, '0);
      pend.delete();
      ld_q.delete();
      arch.delete();
    end else begin
      e_stall = cpuWrEn && (pend.size() == WBUF_DEPTH);
      e_hit   = 1'b0;
      foreach (pend[i]) if (pend[i].w == w) e_hit = 1'b1;
      e_miss  = cpuRdEn && !e_hit;
      e_drain = !e_miss && (pend.size() > 0);
      e_addr  = e_miss ? word_to_addr(w) : (e_drain ? word_to_addr(pend[0].w) : '0);
      e_dout  = e_drain ? pend[0].d : '0;
      check("stall", 32'(stall), 32'(e_stall));
      check("bufEmpty", 32'(bufEmpty), 32'(pend.size() == 0));
      check("memWrEn", 32'(memWrEn), 32'(e_drain));
      check("memAddr", memAddr, e_addr);
      check("memDataOut", memDataOut, e_dout);
      if (cpuRdEn) begin
        ld_issue = 1'b1;
        ld_q.push_back(arch_rd(w));
      end
      if (e_drain) void'(pend.pop_front());
      if (cpuWrEn && !e_stall) begin
        pend.push_back('{w, cpuDataIn});
        arch[int'(w)] = cpuDataIn;
      end
    end
    @(posedge clk);
    #1;
    check("rdValid", 32'(rdValid), 32'(ld_issue));
    if (rdValid) begin
      if (ld_q.size() == 0) check("rd_spurious", 32'(rdValid), 32'd0);
      else check("cpuRdData", cpuRdData, ld_q.pop_front());
    end
    if (was_reset) check("rst_cpuRdData", cpuRdData, '0);
  endtask

  task automatic drive(input logic wr, input logic rd, input word_t addr, input word_t data);
    cpuWrEn   = wr;
    cpuRdEn   = rd;
    cpuAddr   = addr;
    cpuDataIn = data;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    cpuWrEn   = 1'b0;
    cpuRdEn   = 1'b0;
    cpuAddr   = '0;
    cpuDataIn = '0;
    pre_en    = 1'b0;
    pre_idx   = '0;
    pre_data  = '0;
    @(posedge clk);
    #1;
    step();
    step();
    reset = 1'b0;
    idle(5);

    // Single store drains the next cycle, then the queue is empty.
    drive(1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    idle(2);

    // Drain blocked by load misses: fifth store stalls until the load stops.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 32'h200 + 32'(4 * i), 32'h100 + 32'(i));
    drive(1'b1, 1'b1, 32'h210, 32'h104);
    drive(1'b1, 1'b0, 32'h210, 32'h104);
    drive(1'b1, 1'b0, 32'h210, 32'h104);
    idle(6);

    // Two stores to the same word queued; load with offset 3 gets the youngest.
    drive(1'b1, 1'b1, 32'h300, 32'h33);
    drive(1'b1, 1'b1, 32'h20, 32'h11);
    drive(1'b1, 1'b1, 32'h20, 32'h22);
    drive(1'b0, 1'b1, 32'h23, '0);
    idle(4);

    // Load miss on an empty buffer is served by memory.
    pre_en   = 1'b1;
    pre_idx  = addr_to_word(32'h40);
    pre_data = 32'h55;
    arch[int'(addr_to_word(32'h40))] = 32'h55;
    idle(1);
    pre_en = 1'b0;
    drive(1'b0, 1'b1, 32'h40, '0);
    idle(1);

    // Same-cycle store and load to one word: load sees the old value.
    drive(1'b1, 1'b1, 32'h60, 32'h77);
    drive(1'b0, 1'b1, 32'h60, '0);
    idle(2);

    // Random mix over a few words to exercise hits, misses and wrap.
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            32'h80 + 32'($urandom_range(0, 15)), $urandom);
    end
    idle(6);

    // Reset with stores pending discards them; memory is cleared too.
    drive(1'b1, 1'b1, 32'h400, 32'hA1);
    drive(1'b1, 1'b1, 32'h404, 32'hA2);
    drive(1'b1, 1'b1, 32'h408, 32'hA3);
    cpuWrEn = 1'b0;
    cpuRdEn = 1'b0;
    reset   = 1'b1;
    step();
    reset = 1'b0;
    idle(3);
    drive(1'b0, 1'b1, 32'h404, '0);
    drive(1'b0, 1'b1, 32'h10, '0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_write_buffer.md
Name: dmem_write_buffer

Overview:
- Store-queue stage directly upstream of the data-memory register file (registered address/data, negedge write, combinational read of the registered word).
- Decouples CPU stores from the single memory port:
  - Stores are queued in a small FIFO and drained one per cycle.
  - Loads are forwarded from the queue on a hit, or get the memory port on a miss.
- Sits between the datapath's load/store signals and the memory's isWrRegMem/addr/dataIn inputs; provides uniform one-cycle load latency back to the CPU.

Parameters:
- DATA_BIT_WIDTH, 32: data and address bus width.
- DMEMADDRBITS, 13: number of byte-address bits decoded by the data memory.
- DMEMWORDBITS, 2: byte-offset bits; the word index is addr[DMEMADDRBITS-1:DMEMWORDBITS].
- WBUF_DEPTH, 4: number of queue entries; must be a power of two, ≥2.

Ports:
- clk  in  1  system clock, posedge logic.
- reset  in  1  reset, synchronous, active-high.
- cpuWrEn  in  1  store request this cycle.
- cpuRdEn  in  1  load request this cycle.
- cpuAddr  in  DATA_BIT_WIDTH  byte address of the load/store.
- cpuDataIn  in  DATA_BIT_WIDTH  store data.
- stall  out  1  store not accepted this cycle; CPU holds its request.
- cpuRdData  out  DATA_BIT_WIDTH  load result, valid when rdValid=1.
- rdValid  out  1  registered; high the cycle after an accepted load.
- bufEmpty  out  1  queue holds no entries (used for fence/halt).
- memWrEn  out  1  drives the memory's write enable.
- memAddr  out  DATA_BIT_WIDTH  drives the memory address; word bits only, offset bits driven 0.
- memDataOut  out  DATA_BIT_WIDTH  drives the memory data input.
- memRegOut  in  DATA_BIT_WIDTH  memory read data, reflecting the address sampled at the previous posedge.

Behaviour:
- Reset (sync, active-high):
  - head/tail/count ← 0; all entry valid bits ← 0.
  - rdValid ← 0, forward-select register ← 0, forward-data register ← 0.
  - Outputs during and after reset: stall=0, bufEmpty=1, memWrEn=0, memAddr=0, memDataOut=0, cpuRdData=0.
  - Reset mid-drain discards all pending stores; the memory clears itself on the same reset.
- Entry format: word index (DMEMADDRBITS-DMEMWORDBITS bits) + data. Address compares use the word index only.
- Enqueue:
  - cpuWrEn && count<WBUF_DEPTH: entry written at tail on posedge; tail increments mod WBUF_DEPTH; count++.
  - stall = cpuWrEn && (count==WBUF_DEPTH). This is combinational and independent of drain; no push-while-full even if a pop occurs the same cycle.
- Port arbitration each cycle, decided combinationally:
  - Load miss (cpuRdEn, no matching valid entry): port goes to the load. memAddr=load word, memWrEn=0; drain is paused this cycle.
  - Otherwise, if count>0: drain. memWrEn=1, memAddr/memDataOut = head entry; head pops on the same posedge (the memory samples addr/data there and writes on the following negedge); count--.
  - Otherwise: memWrEn=0, memAddr=0, memDataOut=0.
- Load forwarding:
  - Hit = any valid entry whose word index equals cpuAddr's word index. The youngest matching entry (closest to tail) wins.
  - The hit's data is captured into the forward-data register; the forward-select register ← 1.
  - Miss: forward-select ← 0.
  - Next cycle: rdValid=1; cpuRdData = forward-select ? forward-data : memRegOut.
  - Load latency is exactly 1 cycle in both cases.
- Simultaneous events:
  - cpuWrEn && cpuRdEn: the store is enqueued (if not full); the load checks pre-existing entries only, never the same-cycle store.
  - Head entry draining in the same cycle as a hitting load: forward still uses the head data (entry is valid during that cycle).
  - Enqueue and dequeue in the same cycle: count unchanged.
- Pointer wrap: natural modulo via log2(WBUF_DEPTH)-bit pointers; count is log2(WBUF_DEPTH)+1 bits.
- bufEmpty = (count==0); combinational from registered count.

Decomposition:
- Shared package holds:
  - WBUF_PTR_BITS = $clog2(WBUF_DEPTH).
  - Word-index width constant (DMEMADDRBITS-DMEMWORDBITS).
  - wbuf_entry_t struct {valid, wordIdx, data}.
- One sub-module, wbuf_forward_match: combinational youngest-match priority selector.
  - Inputs: entry array, head, count, compare word.
  - Outputs: hit, data.
- FIFO storage and arbitration live in the top module.

Test Plan:
- Reset then idle → bufEmpty=1, memWrEn=0, stall=0, rdValid=0 for 5 cycles.
- Store 0x0000_0010 ← 0xDEADBEEF, no loads → next cycle memWrEn=1, memAddr=0x10, memDataOut=0xDEADBEEF; following cycle bufEmpty=1.
- Five back-to-back stores with a load miss held every cycle (drain blocked) → fifth store sees stall=1 with count=4. Release the load → drain resumes, stall drops, and the fifth store is accepted.
- Stores 0x20←0x11, then 0x20←0x22 (queued), then load 0x23 → rdValid next cycle with cpuRdData=0x22 (youngest match, offset bits ignored).
- Load 0x40 with an empty buffer, memory preloaded 0x55 → memAddr=0x40, memWrEn=0; next cycle cpuRdData=0x55, rdValid=1.
- Three stores queued, assert reset one cycle → bufEmpty=1, memWrEn=0 the cycle after; no further writes are issued.
